// File: rtl/jj_pattern_gen.sv
// Serial burst pattern generator for the jj/enable detector interface.
// Optional pause feature compiled in with `define GEN_PAUSE_EN.
module jj_pattern_gen #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  input  logic [LEN_W-1:0] gap_len,
  input  logic [CNT_W-1:0] bursts,
`ifdef GEN_PAUSE_EN
  input  logic             pause,
`endif
  output logic             jj,
  output logic             en_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_cnt, len_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_nxt;
  logic [LEN_W-1:0] run_q, run_q_nxt;
  logic [LEN_W-1:0] gap_q, gap_q_nxt;
  logic             hold_c;

  // Pause freezes only the active pattern states.
`ifdef GEN_PAUSE_EN
  assign hold_c = pause && ((state == HIGH) || (state == LOW));
`else
  assign hold_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_cnt   <= '0;
      burst_cnt <= '0;
      run_q     <= '0;
      gap_q     <= '0;
      jj        <= 1'b0;
      en_out    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      len_cnt   <= len_nxt;
      burst_cnt <= burst_nxt;
      run_q     <= run_q_nxt;
      gap_q     <= gap_q_nxt;
      jj        <= (state_nxt == HIGH);
      en_out    <= !hold_c;
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len_cnt;
    burst_nxt = burst_cnt;
    run_q_nxt = run_q;
    gap_q_nxt = gap_q;
    case (state)
      IDLE: begin
        if (start) begin
          run_q_nxt = run_len;
          gap_q_nxt = gap_len;
          if ((bursts == '0) || (run_len == '0)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = HIGH;
            len_nxt   = run_len - LEN_W'(1);
            burst_nxt = bursts;
          end
        end
      end
      HIGH: begin
        if (!hold_c) begin
          if (len_cnt == '0) begin
            burst_nxt = burst_cnt - CNT_W'(1);
            if (burst_cnt == CNT_W'(1)) begin
              state_nxt = DONE;
            end else begin
              // A zero gap still separates runs by one low cycle.
              state_nxt = LOW;
              len_nxt   = (gap_q == '0) ? '0 : gap_q - LEN_W'(1);
            end
          end else begin
            len_nxt = len_cnt - LEN_W'(1);
          end
        end
      end
      LOW: begin
        if (!hold_c) begin
          if (len_cnt == '0) begin
            state_nxt = HIGH;
            len_nxt   = run_q - LEN_W'(1);
          end else begin
            len_nxt = len_cnt - LEN_W'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_jj_pattern_gen.sv
// Randomized bench for jj_pattern_gen against a queue-based pattern model.
module tb_jj_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] run_len = '0;
  logic [7:0] gap_len = '0;
  logic [3:0] bursts = '0;
  logic       jj, en_out, busy, done;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jj_pattern_gen #(.LEN_W(8), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .run_len(run_len),
    .gap_len(gap_len),
    .bursts(bursts),
`ifdef GEN_PAUSE_EN
    .pause(pause),
`endif
    .jj(jj),
    .en_out(en_out),
    .busy(busy),
    .done(done)
  );

  // Model: the whole pattern is expanded into a per-cycle queue on start.
  localparam int K_IDLE = 0;
  localparam int K_HIGH = 1;
  localparam int K_LOW  = 2;
  localparam int K_DONE = 3;

  int   q[$];
  int   cur = K_IDLE;
  logic exp_jj = 1'b0;
  logic exp_en = 1'b1;
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;

  task automatic build(input int rl, input int gl, input int b);
    int g;
    q.delete();
    g = (gl == 0) ? 1 : gl;
    if (b != 0 && rl != 0) begin
      for (int i = 0; i < b; i++) begin
        for (int k = 0; k < rl; k++) q.push_back(K_HIGH);
        if (i != b - 1) for (int k = 0; k < g; k++) q.push_back(K_LOW);
      end
    end
    q.push_back(K_DONE);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur = K_IDLE;
      exp_en = 1'b1;
    end else if ((cur == K_HIGH || cur == K_LOW) && pause) begin
      exp_en = 1'b0;
    end else begin
      exp_en = 1'b1;
      if (cur == K_IDLE) begin
        if (start) begin
          build(int'(run_len), int'(gap_len), int'(bursts));
          cur = q.pop_front();
        end
      end else if (cur == K_DONE) begin
        cur = K_IDLE;
      end else begin
        cur = q.pop_front();
      end
    end
    exp_jj   = (cur == K_HIGH);
    exp_busy = (cur != K_IDLE);
    exp_done = (cur == K_DONE);
  end

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // One cycle: compare outputs mid-cycle, then apply new inputs.
  task automatic step(input logic r, input logic s, input int rl, input int gl,
                      input int b, input logic p);
    @(negedge clk);
    check_eq("jj", int'(jj), int'(exp_jj));
    check_eq("en_out", int'(en_out), int'(exp_en));
    check_eq("busy", int'(busy), int'(exp_busy));
    check_eq("done", int'(done), int'(exp_done));
    rst     = r;
    start   = s;
    run_len = 8'(rl);
    gap_len = 8'(gl);
    bursts  = 4'(b);
`ifdef GEN_PAUSE_EN
    pause   = p;
`else
    pause   = 1'b0 & p;
`endif
  endtask

  initial begin
    int done_at;
    int jj_high;
    int rl, b;
    // Reset held two cycles
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("reset_jj", int'(jj), 0);
    check_eq("reset_en", int'(en_out), 1);
    check_eq("reset_busy", int'(busy), 0);

    // Two bursts of 5 with gap 3: done lands on cycle 14
    step(0, 1, 5, 3, 2, 0);
    done_at = -1;
    jj_high = 0;
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 1, 7, 0);
      if (done && done_at < 0) done_at = i;
      if (jj) jj_high++;
    end
    check_eq("t2_done_cycle", done_at, 14);
    check_eq("t2_jj_high", jj_high, 10);

    // Zero bursts / zero run length finish immediately
    step(0, 1, 4, 2, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("t3_done_b0", int'(done), 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 2, 3, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("t3_done_rl0", int'(done), 1);
    step(0, 0, 0, 0, 0, 0);

    // Zero gap with a start pulsed mid-pattern
    step(0, 1, 2, 0, 3, 0);
    for (int i = 0; i < 10; i++) step(0, (i == 3), 9, 9, 9, 0);

    // Reset in the middle of a long run
    step(0, 1, 8, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("t5_busy_after_rst", int'(busy), 0);
    check_eq("t5_jj_after_rst", int'(jj), 0);

    // Start held high: back-to-back patterns; also max run length
    for (int i = 0; i < 20; i++) step(0, 1, 3, 1, 2, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 255, 0, 2, 0);
    for (int i = 0; i < 520; i++) step(0, 0, $urandom_range(0, 255), 0, 1, 0);

`ifdef GEN_PAUSE_EN
    // Pause for 4 cycles inside a run of 6
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 6, 1, 1, 0);
    for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 0, (i >= 1 && i <= 4));
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rl = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 6));
      b  = (rl < 8 && $urandom_range(0, 19) == 0) ? 15 : int'($urandom_range(0, 4));
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), rl,
           $urandom_range(0, 4), b, ($urandom_range(0, 5) == 0));
    end
    step(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
